// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with blocking fill from the memory controller.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic [31:0]       imemload,
    output logic              ihit,
    input  logic              inv,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e              state_q;
    logic [ADDR_W-1:2]   maddr_q;
    logic                inv_pend_q;
    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    midx;
    logic [TAG_W-1:0]    mtag;
    logic                hit;
    logic                start_fill;
    logic                unused_byte_bits;

    assign idx  = imemaddr[IDX_W+1:2];
    assign tag  = imemaddr[ADDR_W-1:IDX_W+2];
    assign midx = maddr_q[IDX_W+1:2];
    assign mtag = maddr_q[ADDR_W-1:IDX_W+2];

    // Fetch addresses are word aligned; the byte offset never reaches the cache.
    assign unused_byte_bits = ^imemaddr[1:0];

    assign hit        = imemREN && valid_q[idx] && (tag_q[idx] == tag) && (state_q == StIdle);
    assign start_fill = (state_q == StIdle) && imemREN && !hit && !inv;

    assign ihit     = hit;
    assign imemload = hit ? data_q[idx] : 32'h0;
    assign iREN     = (state_q == StFill);
    assign iaddr    = iREN ? {maddr_q, 2'b00} : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            maddr_q    <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_fill) begin
                        state_q    <= StFill;
                        maddr_q    <= imemaddr[ADDR_W-1:2];
                        inv_pend_q <= 1'b0;
                    end
                end
                StFill: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (!iwait) begin
                        data_q[midx]  <= iload;
                        tag_q[midx]   <= mtag;
                        // An invalidate seen at any point during the fill discards the line.
                        valid_q[midx] <= ~(inv_pend_q | inv);
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (inv) begin
                valid_q <= '0;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_fill) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 32'h0;
    assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized scoreboard bench for icache_direct: a set-indexed reference model predicts each
// ihit (data and latency); a negedge monitor pops and compares, and also polices iREN/iaddr.
module tb_icache_direct;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic [31:0] imemload;
    logic        ihit;
    logic        inv = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_direct dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .imemload (imemload),
        .ihit     (ihit),
        .inv      (inv),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backing memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    // Reference model: which word address each set holds, if any.
    bit          mvalid [SETS];
    logic [31:0] mline  [SETS];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return mvalid[set_of(a)] && (mline[set_of(a)] == {a[31:2], 2'b00});
    endfunction

    function automatic void mclear();
        for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          start;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] exp_maddr = 32'hFFFF_FFFF;
    bit          mon_en = 1'b0;
    int          cur_wait = 0;
    int          fill_cyc = 0;

    // Memory controller: holds iwait high for cur_wait cycles of each fill, then returns data.
    always @(negedge CLK) begin
        if (iREN === 1'b1) begin
            iwait = (fill_cyc < cur_wait);
            iload = mem_word(iaddr);
            fill_cyc++;
        end else begin
            fill_cyc = 0;
            iwait = 1'($urandom_range(0, 1));
            iload = $urandom;
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            if (ihit === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ihit", {31'b0, ihit}, 32'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("imemload", imemload, e.data);
                    if (e.lat >= 0) chk("hit_latency", 32'(cyc - e.start), 32'(e.lat));
                end
            end else begin
                chk("imemload_nohit", imemload, 32'h0);
            end
            if (iREN === 1'b1) chk("iaddr_fill", iaddr, exp_maddr);
            else               chk("iaddr_idle", iaddr, 32'h0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input int w);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        imemREN  = 1'b1;
        imemaddr = a;
        inv      = 1'b0;
        m_hits++;
        if (mhit(a)) begin
            sbq.push_back('{mem_word(wa), 0, cyc});
            step();
        end else begin
            cur_wait  = w;
            exp_maddr = wa;
            m_misses++;
            sbq.push_back('{mem_word(wa), w + 2, cyc});
            mvalid[set_of(a)] = 1'b1;
            mline[set_of(a)]  = wa;
            repeat (w + 3) step();
        end
        imemREN = 1'b0;
    endtask

    // Fetch redirects from a to b r cycles into a's fill; the fill still completes to a.
    task automatic redirect(input logic [31:0] a, input logic [31:0] b, input int w, input int r,
                            input int w2);
        if (mhit(a)) begin
            req(a, w);
        end else begin
            imemREN   = 1'b1;
            imemaddr  = a;
            cur_wait  = w;
            exp_maddr = {a[31:2], 2'b00};
            m_misses++;
            repeat (r) step();
            imemaddr = b;
            repeat (w + 2 - r) step();
            mvalid[set_of(a)] = 1'b1;
            mline[set_of(a)]  = {a[31:2], 2'b00};
            req(b, w2);
        end
    endtask

    // inv lands on the first fill cycle, so the completing line must come back invalid.
    task automatic invfill(input logic [31:0] a, input int w);
        if (mhit(a)) begin
            req(a, w);
        end else begin
            imemREN   = 1'b1;
            imemaddr  = a;
            cur_wait  = w;
            exp_maddr = {a[31:2], 2'b00};
            m_misses++;
            step();
            inv = 1'b1;
            step();
            inv = 1'b0;
            mclear();
            repeat (w) step();
            imemREN = 1'b0;
        end
    endtask

    // A miss coinciding with inv only invalidates; no fill may start.
    task automatic invmiss(input logic [31:0] a);
        if (mhit(a)) begin
            req(a, 0);
        end else begin
            imemREN   = 1'b1;
            imemaddr  = a;
            inv       = 1'b1;
            exp_maddr = 32'hFFFF_FFFF;
            step();
            inv     = 1'b0;
            imemREN = 1'b0;
            mclear();
        end
    endtask

    task automatic idle(input int n, input bit allow_inv);
        for (int i = 0; i < n; i++) begin
            imemREN   = 1'b0;
            imemaddr  = $urandom;
            exp_maddr = 32'hFFFF_FFFF;
            inv       = allow_inv && ($urandom_range(0, 7) == 0);
            if (inv) mclear();
            step();
        end
        inv = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t;
        logic [31:0] s;
        t = $urandom_range(0, 3);
        s = $urandom_range(0, SETS - 1);
        return (t << 6) | (s << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        mclear();
        step();
        step();
        chk("reset_iREN", {31'b0, iREN}, 32'h0);
        chk("reset_ihit", {31'b0, ihit}, 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        chk("reset_hit_cnt", hit_cnt, 32'h0);
        chk("reset_miss_cnt", miss_cnt, 32'h0);
        nRST   = 1'b1;
        mon_en = 1'b1;
        step();

        // Directed: cold miss, repeat hits, conflict eviction, redirect, inv mid-fill.
        req(32'h40, 3);
        req(32'h40, 0);
        req(32'h40, 1);
        req(32'h40, 2);
        req(32'h440, 2);
        req(32'h40, 1);
        redirect(32'h80, 32'h100, 3, 2, 1);
        req(32'h80, 0);
        invfill(32'hC0, 3);
        req(32'hC0, 1);
        req(32'h100, 0);
        invmiss(32'h1234);
        idle(3, 1'b0);

        for (int n = 0; n < 250; n++) begin
            int op;
            int w;
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 4);
            case (op)
                0:       redirect(rand_addr(), rand_addr(), w, $urandom_range(1, w + 1),
                                  $urandom_range(0, 3));
                1:       invfill(rand_addr(), w);
                2:       invmiss(rand_addr());
                3:       idle($urandom_range(1, 3), 1'b1);
                default: req(rand_addr(), w);
            endcase
        end
        idle(3, 1'b0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
`else
        chk("hit_cnt_off", hit_cnt, 32'h0);
        chk("miss_cnt_off", miss_cnt, 32'h0);
`endif

        // Asynchronous reset in the middle of a fill.
        req(32'h40, 0);
        imemREN   = 1'b1;
        imemaddr  = 32'h2004;
        cur_wait  = 5;
        exp_maddr = 32'h2004;
        step();
        step();
        chk("fill_before_reset", {31'b0, iREN}, 32'h1);
        mon_en = 1'b0;
        nRST   = 1'b0;
        #1;
        chk("async_reset_iREN", {31'b0, iREN}, 32'h0);
        chk("async_reset_iaddr", iaddr, 32'h0);
        chk("async_reset_hit_cnt", hit_cnt, 32'h0);
        chk("async_reset_miss_cnt", miss_cnt, 32'h0);
        imemREN = 1'b0;
        step();
        nRST = 1'b1;
        mclear();
        mon_en = 1'b1;
        step();
        req(32'h40, 1);
        idle(2, 1'b0);
        chk("scoreboard_final", 32'(sbq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
